hybrid_decrypt: RTL

- Streaming decryptor for the hybrid cipher: Vigenere followed by 5x5 Polybius, two ASCII digits per plaintext letter.
- Accepts ciphertext one ASCII digit per handshake and pairs digits into (row, col).
- Inverts the Polybius square, then subtracts the repeating key letter, and emits one uppercase ASCII letter per pair.
- Sits at the receive end of the cipher datapath.

---
 rtl/hybrid_cipher_pkg.sv | 21 ++
 rtl/hybrid_decrypt_polybius_decode.sv | 12 +
 rtl/hybrid_decrypt.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hybrid_cipher_pkg.sv
// Shared constants, FSM state type and Polybius helper for the hybrid cipher
// (Vigenere followed by a 5x5 Polybius square with I/J sharing one cell).
package hybrid_cipher_pkg;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam int         ALPHA       = 26;
  localparam int         GRID        = 5;
  localparam int         POLY_J_SKIP = 8;

  typedef enum logic [1:0] {ROW, COL, EMIT} state_t;

  // Grid cell (row, col) to letter index 0..25; cells above 'I' skip 'J'.
  function automatic logic [4:0] polybius_to_letter(input logic [2:0] r,
                                                    input logic [2:0] c);
    logic [4:0] p5;
    p5 = 5'(r) * 5'(GRID) + 5'(c);
    return (p5 <= 5'(POLY_J_SKIP)) ? p5 : p5 + 5'd1;
  endfunction

endpackage

// File: rtl/hybrid_decrypt_polybius_decode.sv
// Combinational inverse of the Polybius square: (row, col) -> letter index.
module polybius_decode
  import hybrid_cipher_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic [4:0] letter
);

  assign letter = polybius_to_letter(row, col);

endmodule

// File: rtl/hybrid_decrypt.sv
// Streaming hybrid-cipher decryptor: pairs ASCII digits into Polybius cells,
// inverts the square, subtracts the repeating key letter and emits one
// uppercase letter per pair.
// Optional feature macro: HYBRID_DECRYPT_ERR_CHECK_EN (invalid-digit detection
// with sticky err); when undefined, out-of-range digits are clamped and err=0.
module hybrid_decrypt
  import hybrid_cipher_pkg::*;
#(
  parameter int N  = 12,
  parameter int KW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [8*N-1:0] key,
  input  logic           msg_start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_digit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_char,
  output logic           msg_done,
  output logic           err
);

  state_t        state, state_next;
  logic [KW-1:0] char_idx;
  logic [2:0]    row_q;
  logic [2:0]    digit_val;
  logic          digit_ok;
  logic          start_ok;
  logic          accept;
  logic          out_fire;
  logic          idx_last;
  logic [4:0]    cipher_letter;
  logic [7:0]    key_char;
  logic [7:0]    key_off;
  logic [7:0]    letter8;
  logic [7:0]    plain_off;

  // msg_start is ignored only while an output is stalled by the consumer.
  assign start_ok = msg_start && !(out_valid && !out_ready);
  assign out_fire = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign idx_last = (char_idx == KW'(N - 1));

`ifdef HYBRID_DECRYPT_ERR_CHECK_EN
  // Only '1'..'5' are legal; anything else is flagged and its pair dropped.
  always_comb begin
    digit_ok  = (in_digit >= ASCII_ONE) && (in_digit <= ASCII_ONE + 8'd4);
    digit_val = digit_ok ? 3'(in_digit - ASCII_ONE) : 3'd0;
  end
`else
  // Out-of-range digits clamp to the nearest grid edge instead of erroring.
  always_comb begin
    digit_ok = 1'b1;
    if (in_digit < ASCII_ONE) begin
      digit_val = 3'd0;
    end else if (in_digit > ASCII_ONE + 8'd4) begin
      digit_val = 3'(GRID - 1);
    end else begin
      digit_val = 3'(in_digit - ASCII_ONE);
    end
  end
`endif

  polybius_decode u_polybius_decode (
    .row    (row_q),
    .col    (digit_val),
    .letter (cipher_letter)
  );

  // Vigenere subtraction against the key letter selected by the char index.
  always_comb begin
    key_char  = key[8*(N-1-int'(char_idx)) +: 8];
    key_off   = key_char - ASCII_A;
    letter8   = {3'b000, cipher_letter};
    plain_off = (letter8 >= key_off) ? letter8 - key_off
                                     : letter8 + 8'(ALPHA) - key_off;
  end

  // Next-state and in_ready; msg_start outranks a simultaneous digit.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ROW: begin
        in_ready = !msg_start;
        if (start_ok)      state_next = ROW;
        else if (in_valid) state_next = digit_ok ? COL : ROW;
      end
      COL: begin
        in_ready = !msg_start;
        if (start_ok)      state_next = ROW;
        else if (in_valid) state_next = digit_ok ? EMIT : ROW;
      end
      EMIT: begin
        in_ready = out_ready && !msg_start;
        if (out_fire) begin
          if (start_ok)                  state_next = ROW;
          else if (in_valid && digit_ok) state_next = COL;
          else                           state_next = ROW;
        end
      end
      default: state_next = ROW;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ROW;
    else        state <= state_next;
  end

  // Datapath: row latch, output register, char index and msg_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_idx  <= '0;
      row_q     <= 3'd0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= out_fire && idx_last;
      if (out_fire) out_valid <= 1'b0;
      if (start_ok)      char_idx <= '0;
      else if (out_fire) char_idx <= idx_last ? '0 : char_idx + 1'b1;
      if (accept && digit_ok) begin
        if (state == COL) begin
          out_char  <= ASCII_A + plain_off;
          out_valid <= 1'b1;
        end else begin
          row_q <= digit_val;
        end
      end
    end
  end

`ifdef HYBRID_DECRYPT_ERR_CHECK_EN
  // Sticky invalid-digit flag, cleared by reset or an accepted msg_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err <= 1'b0;
    else if (start_ok)            err <= 1'b0;
    else if (accept && !digit_ok) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
